sram_read_aligner: RTL



---
 rtl/sram_read_aligner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sram_read_aligner.sv
// SRAM read aligner: issues SRAM reads, tracks them through the fixed read
// latency and returns right-aligned, extended sub-word slices in request order.
module sram_read_aligner #(
  parameter  int DATA_W     = 32,
  parameter  int READ_LAT   = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int LOG_W      = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_conf,
  input  logic [LOG_W-1:0]  i_req_addr,
  input  logic              i_req_sext,
  output logic              o_sram_ren,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err
);
  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam int         CNT_W    = PTR_W + 1;
  localparam logic [2:0] CONF_MAX = 3'(LOG_W);

  typedef struct packed {
    logic             vld;
    logic             err;
    logic             sext;
    logic [2:0]       conf;
    logic [LOG_W-1:0] off;
  } tag_t;

  tag_t              r_tag [READ_LAT];
  tag_t              w_tag_in;
  tag_t              w_tag_out;
  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_pop;
  logic [LOG_W-1:0]  w_shamt;
  logic [LOG_W-1:0]  w_msb_idx;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_aligned;
  logic              w_sign;
  int                w_width;
  logic [CNT_W-1:0]  w_occ_nxt;

  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_occ;
  logic              r_ready;

  assign w_legal    = (i_req_conf <= CONF_MAX);
  assign w_accept   = i_req_valid & r_ready;
  assign o_sram_ren = w_accept & w_legal;

  always_comb begin
    w_tag_in      = '0;
    w_tag_in.vld  = w_accept;
    w_tag_in.err  = ~w_legal;
    w_tag_in.sext = i_req_sext;
    w_tag_in.conf = i_req_conf;
    for (int b = 0; b < LOG_W; b++)
      w_tag_in.off[b] = i_req_addr[b] & (b < int'(i_req_conf));
  end

  // Tags advance every cycle; the SRAM latency is fixed so nothing ever stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < READ_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out = r_tag[READ_LAT-1];

  // Slice width is 2^(LOG_W-conf), so off*width is a plain left shift.
  always_comb begin
    w_width   = DATA_W >> w_tag_out.conf;
    w_shamt   = '0;
    w_msb_idx = '0;
    w_shifted = '0;
    w_sign    = 1'b0;
    w_aligned = '0;
    if (!w_tag_out.err) begin
      w_shamt   = LOG_W'(int'(w_tag_out.off) << (LOG_W - int'(w_tag_out.conf)));
      w_msb_idx = LOG_W'(w_width - 1);
      w_shifted = i_sram_rdata >> w_shamt;
      w_sign    = w_tag_out.sext & w_shifted[w_msb_idx];
      for (int b = 0; b < DATA_W; b++)
        w_aligned[b] = (b < w_width) ? w_shifted[b] : w_sign;
    end
  end

  assign w_push      = w_tag_out.vld;
  assign o_rsp_valid = (r_count != '0);
  assign w_pop       = o_rsp_valid & i_rsp_ready;
  assign o_rsp_data  = r_mem_data[r_rd_ptr];
  assign o_rsp_err   = r_mem_err[r_rd_ptr];
  assign o_req_ready = r_ready;

  // occ counts in-flight tags plus buffered entries, so a full credit pool
  // guarantees a FIFO slot for every tag still in the pipeline.
  assign w_occ_nxt = r_occ + CNT_W'(w_accept) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_err[i]  <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_occ    <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_aligned;
        r_mem_err[r_wr_ptr]  <= w_tag_out.err;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_occ   <= w_occ_nxt;
      r_ready <= (w_occ_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

endmodule
